// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller.
// Optional feature macro: MADD_ACC_EN (multiply-accumulate/subtract ops 9-12).
package hilo_mdu_ctrl_pkg;

  // Execute-stage request opcodes
  localparam logic [3:0] REQ_NOP   = 4'd0;
  localparam logic [3:0] REQ_MULT  = 4'd1;
  localparam logic [3:0] REQ_MULTU = 4'd2;
  localparam logic [3:0] REQ_DIV   = 4'd3;
  localparam logic [3:0] REQ_DIVU  = 4'd4;
  localparam logic [3:0] REQ_MTHI  = 4'd5;
  localparam logic [3:0] REQ_MTLO  = 4'd6;
  localparam logic [3:0] REQ_MFHI  = 4'd7;
  localparam logic [3:0] REQ_MFLO  = 4'd8;
  localparam logic [3:0] REQ_MADD  = 4'd9;
  localparam logic [3:0] REQ_MADDU = 4'd10;
  localparam logic [3:0] REQ_MSUB  = 4'd11;
  localparam logic [3:0] REQ_MSUBU = 4'd12;

  // Operation codes understood by the multiply/divide unit
  localparam logic [1:0] MD_IDLE = 2'b00;
  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // True for opcodes that start a transaction on the unit
  function automatic logic starts_md(input logic [3:0] op);
    logic r;
    r = (op >= REQ_MULT) && (op <= REQ_DIVU);
`ifdef MADD_ACC_EN
    r = r || ((op >= REQ_MADD) && (op <= REQ_MSUBU));
`endif
    return r;
  endfunction

  // True for opcodes that must wait while the unit is busy (anything but NOP-like codes)
  function automatic logic op_stalls(input logic [3:0] op);
    logic r;
    r = (op >= REQ_MULT) && (op <= REQ_MFLO);
`ifdef MADD_ACC_EN
    r = r || ((op >= REQ_MADD) && (op <= REQ_MSUBU));
`endif
    return r;
  endfunction

  // Unit operation for an issuing opcode
  function automatic logic [1:0] md_op_of(input logic [3:0] op);
    return ((op == REQ_DIV) || (op == REQ_DIVU)) ? MD_DIV : MD_MUL;
  endfunction

  // Signed variants: MULT, DIV, MADD, MSUB
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == REQ_MULT) || (op == REQ_DIV) || (op == REQ_MADD) || (op == REQ_MSUB);
  endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_hilo_regfile.sv
// Architectural HI/LO storage: MT write port, result write-back and,
// with MADD_ACC_EN defined, the 64-bit accumulate/subtract adder.
module hilo_regfile
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             wb_en,
`ifdef MADD_ACC_EN
  input  logic             wb_acc,
  input  logic             wb_sub,
`endif
  input  logic [WIDTH-1:0] res0,
  input  logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] wb_value;

  // Select the 64-bit value written on a response: raw result or accumulated
  always_comb begin
    wb_value = {res1, res0};
`ifdef MADD_ACC_EN
    if (wb_acc) begin
      if (wb_sub) wb_value = {hi, lo} - {res1, res0};
      else        wb_value = {hi, lo} + {res1, res0};
    end
`endif
  end

  // HI/LO update: unit write-back and MT writes never coincide (MT only in IDLE)
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (wb_en) begin
      {hi, lo} <= wb_value;
    end else begin
      if (mt_hi) hi <= mt_data;
      if (mt_lo) lo <= mt_data;
    end
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// Pipeline-side initiator for the multiply/divide unit: latches requests,
// runs the valid/ready request/response handshakes, owns HI/LO and stalls
// the pipeline while a mult/div is outstanding.
// Optional feature macro: MADD_ACC_EN (MADD/MADDU/MSUB/MSUBU accumulate).
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] md_src0,
  output logic [WIDTH-1:0] md_src1,
  output logic [1:0]       md_op,
  output logic             md_sign,
  output logic             md_in_valid,
  input  logic             md_in_ready,
  input  logic             md_out_valid,
  output logic             md_out_ready,
  input  logic [WIDTH-1:0] md_res0,
  input  logic [WIDTH-1:0] md_res1
);

  state_t state_reg;
  logic   idle_req;
  logic   mt_hi;
  logic   mt_lo;
  logic   wb_en;
`ifdef MADD_ACC_EN
  logic   acc_reg;
  logic   sub_reg;
`endif

  // Request/response side decodes; MT writes only happen when the request is accepted
  always_comb begin
    idle_req = req_valid && (state_reg == IDLE);
    mt_hi    = idle_req && (req_op == REQ_MTHI);
    mt_lo    = idle_req && (req_op == REQ_MTLO);
    wb_en    = (state_reg == WAIT) && md_out_valid && md_out_ready;
    stall    = req_valid && (state_reg != IDLE) && op_stalls(req_op);
  end

  // Handshake FSM with registered channel outputs; md_op is only non-idle in ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      md_src0      <= '0;
      md_src1      <= '0;
      md_op        <= MD_IDLE;
      md_sign      <= 1'b0;
      md_in_valid  <= 1'b0;
      md_out_ready <= 1'b0;
`ifdef MADD_ACC_EN
      acc_reg      <= 1'b0;
      sub_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && starts_md(req_op)) begin
            state_reg   <= ISSUE;
            md_src0     <= req_a;
            md_src1     <= req_b;
            md_op       <= md_op_of(req_op);
            md_sign     <= is_signed_op(req_op);
            md_in_valid <= 1'b1;
`ifdef MADD_ACC_EN
            acc_reg     <= (req_op >= REQ_MADD);
            sub_reg     <= (req_op == REQ_MSUB) || (req_op == REQ_MSUBU);
`endif
          end
        end
        ISSUE: begin
          if (md_in_ready) begin
            state_reg    <= WAIT;
            md_in_valid  <= 1'b0;
            md_op        <= MD_IDLE;
            md_out_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (md_out_valid) begin
            state_reg    <= IDLE;
            md_out_ready <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  hilo_regfile #(.WIDTH(WIDTH)) u_hilo (
    .clk     (clk),
    .reset   (reset),
    .mt_hi   (mt_hi),
    .mt_lo   (mt_lo),
    .mt_data (req_a),
    .wb_en   (wb_en),
`ifdef MADD_ACC_EN
    .wb_acc  (acc_reg),
    .wb_sub  (sub_reg),
`endif
    .res0    (md_res0),
    .res1    (md_res1),
    .hi      (hi),
    .lo      (lo)
  );

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed self-checking bench for hilo_mdu_ctrl; the bench plays the
// multiply/divide unit with hand-computed results.
module tb_hilo_mdu_ctrl;
  import hilo_mdu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        stall;
  logic [31:0] hi, lo, md_src0, md_src1;
  logic [1:0]  md_op;
  logic        md_sign, md_in_valid, md_in_ready, md_out_valid, md_out_ready;
  logic [31:0] md_res0, md_res1;

  int checks;
  int failures;

  hilo_mdu_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .stall(stall), .hi(hi), .lo(lo),
    .md_src0(md_src0), .md_src1(md_src1), .md_op(md_op), .md_sign(md_sign),
    .md_in_valid(md_in_valid), .md_in_ready(md_in_ready),
    .md_out_valid(md_out_valid), .md_out_ready(md_out_ready),
    .md_res0(md_res0), .md_res1(md_res1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset_hilo hi=%h lo=%h want 0/0", hi, lo);
    end
    checks++;
    if (md_in_valid !== 1'b0 || md_out_ready !== 1'b0 || md_op !== 2'b00 || md_sign !== 1'b0) begin
      failures++; $display("FAIL reset_chan in_valid=%b out_ready=%b op=%b sign=%b want 0", md_in_valid, md_out_ready, md_op, md_sign);
    end
    checks++;
    if (md_src0 !== 32'h0 || md_src1 !== 32'h0 || stall !== 1'b0) begin
      failures++; $display("FAIL reset_src src0=%h src1=%h stall=%b want 0", md_src0, md_src1, stall);
    end
    $display("txn reset: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_mult(input logic [3:0] op, input logic sgn, input logic [31:0] p_hi, input logic [31:0] p_lo);
    tick();
    req_valid = 1'b1; req_op = op; req_a = 32'hFFFF_FFFF; req_b = 32'd2;
    md_in_ready = 1'b1; md_out_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL mult_accept stall=%b want 0", stall); end
    tick(); // cycle 1: issue handshake
    req_valid = 1'b0;
    #1;
    checks++;
    if (md_in_valid !== 1'b1 || md_op !== MD_MUL || md_sign !== sgn) begin
      failures++; $display("FAIL mult_issue valid=%b op=%b sign=%b want 1/01/%b", md_in_valid, md_op, md_sign, sgn);
    end
    checks++;
    if (md_src0 !== 32'hFFFF_FFFF || md_src1 !== 32'd2) begin
      failures++; $display("FAIL mult_src src0=%h src1=%h want ffffffff/2", md_src0, md_src1);
    end
    tick(); // cycle 2: response
    md_out_valid = 1'b1; md_res1 = p_hi; md_res0 = p_lo;
    #1;
    checks++;
    if (md_out_ready !== 1'b1 || md_op !== MD_IDLE || md_in_valid !== 1'b0) begin
      failures++; $display("FAIL mult_wait out_ready=%b op=%b in_valid=%b want 1/00/0", md_out_ready, md_op, md_in_valid);
    end
    tick(); // cycle 3: results visible, dependent MFHI not stalled
    md_out_valid = 1'b0;
    req_valid = 1'b1; req_op = REQ_MFHI;
    #1;
    checks++;
    if (hi !== p_hi || lo !== p_lo || stall !== 1'b0) begin
      failures++; $display("FAIL mult_result hi=%h lo=%h stall=%b want %h/%h/0", hi, lo, stall, p_hi, p_lo);
    end
    $display("txn mult op=%0d: hi=%h lo=%h", op, hi, lo);
    req_valid = 1'b0;
  endtask

  task automatic test_div_slow();
    int bad;
    tick();
    req_valid = 1'b1; req_op = REQ_DIV; req_a = 32'hFFFF_FFF9; req_b = 32'd2;
    md_in_ready = 1'b0; md_out_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL div_accept stall=%b want 0", stall); end
    // Unit not ready for 5 cycles; a dependent MFLO is held the whole time
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      req_op = REQ_MFLO; req_a = 32'h0; req_b = 32'h0;
      #1;
      checks++;
      if (md_in_valid !== 1'b1 || md_op !== MD_DIV || md_sign !== 1'b1 ||
          md_src0 !== 32'hFFFF_FFF9 || md_src1 !== 32'd2 || stall !== 1'b1) begin
        failures++; bad++;
        $display("FAIL div_hold cyc=%0d valid=%b op=%b sign=%b src0=%h src1=%h stall=%b want 1/10/1/fffffff9/2/1",
                 i, md_in_valid, md_op, md_sign, md_src0, md_src1, stall);
      end
    end
    tick();
    md_in_ready = 1'b1;
    #1;
    checks++;
    if (md_in_valid !== 1'b1 || stall !== 1'b1) begin
      failures++; $display("FAIL div_issue valid=%b stall=%b want 1/1", md_in_valid, stall);
    end
    // 20 cycles with no response
    for (int i = 0; i < 20; i++) begin
      tick();
      md_in_ready = 1'b0;
      #1;
      checks++;
      if (md_out_ready !== 1'b1 || stall !== 1'b1 || md_op !== MD_IDLE || md_in_valid !== 1'b0) begin
        failures++; bad++;
        $display("FAIL div_wait cyc=%0d out_ready=%b stall=%b op=%b in_valid=%b want 1/1/00/0", i, md_out_ready, stall, md_op, md_in_valid);
      end
    end
    tick();
    md_out_valid = 1'b1; md_res0 = 32'hFFFF_FFFD; md_res1 = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL div_resp_stall stall=%b want 1", stall); end
    tick();
    md_out_valid = 1'b0;
    #1;
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || stall !== 1'b0) begin
      failures++; $display("FAIL div_result hi=%h lo=%h stall=%b want ffffffff/fffffffd/0", hi, lo, stall);
    end
    $display("txn div -7/2: hi=%h lo=%h hold_errors=%0d", hi, lo, bad);
    req_valid = 1'b0;
  endtask

  task automatic test_mt();
    tick();
    req_valid = 1'b1; req_op = REQ_MTHI; req_a = 32'h0000_1234;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL mthi_stall stall=%b want 0", stall); end
    tick();
    req_op = REQ_MFHI; req_a = 32'h0;
    #1;
    checks++;
    if (hi !== 32'h0000_1234 || stall !== 1'b0) begin
      failures++; $display("FAIL mthi_value hi=%h stall=%b want 00001234/0", hi, stall);
    end
    tick();
    req_op = REQ_MTLO; req_a = 32'hCAFE_0001;
    tick();
    req_op = REQ_MFLO; req_a = 32'h0;
    #1;
    checks++;
    if (lo !== 32'hCAFE_0001 || hi !== 32'h0000_1234 || md_in_valid !== 1'b0) begin
      failures++; $display("FAIL mtlo_value hi=%h lo=%h in_valid=%b want 00001234/cafe0001/0", hi, lo, md_in_valid);
    end
    $display("txn mt: hi=%h lo=%h", hi, lo);
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    tick();
    req_valid = 1'b1; req_op = REQ_DIVU; req_a = 32'd100; req_b = 32'd7;
    md_in_ready = 1'b1; md_out_valid = 1'b0;
    tick(); // ISSUE; MULT now presented and held
    req_op = REQ_MULT; req_a = 32'd3; req_b = 32'd5;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL b2b_issue_stall stall=%b want 1", stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (stall !== 1'b1 || md_out_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_wait cyc=%0d stall=%b out_ready=%b want 1/1", i, stall, md_out_ready);
      end
    end
    tick();
    md_out_valid = 1'b1; md_res0 = 32'd14; md_res1 = 32'd2;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL b2b_resp_stall stall=%b want 1", stall); end
    tick(); // IDLE: MULT accepted this cycle
    md_out_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
      failures++; $display("FAIL b2b_divu stall=%b hi=%h lo=%h want 0/2/e", stall, hi, lo);
    end
    tick();
    req_valid = 1'b0;
    #1;
    checks++;
    if (md_in_valid !== 1'b1 || md_op !== MD_MUL || md_sign !== 1'b1 || md_src0 !== 32'd3 || md_src1 !== 32'd5) begin
      failures++; $display("FAIL b2b_mult_issue valid=%b op=%b sign=%b src0=%h src1=%h want 1/01/1/3/5",
                           md_in_valid, md_op, md_sign, md_src0, md_src1);
    end
    tick();
    md_out_valid = 1'b1; md_res0 = 32'd15; md_res1 = 32'd0;
    tick();
    md_out_valid = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15) begin
      failures++; $display("FAIL b2b_mult_result hi=%h lo=%h want 0/f", hi, lo);
    end
    $display("txn back_to_back: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset_mid_wait();
    tick();
    req_valid = 1'b1; req_op = REQ_DIV; req_a = 32'd9; req_b = 32'd4;
    md_in_ready = 1'b1; md_out_valid = 1'b0;
    tick();
    req_op = REQ_MFLO;
    tick(); // WAIT
    #1;
    checks++;
    if (stall !== 1'b1 || md_out_ready !== 1'b1) begin
      failures++; $display("FAIL rst_pre stall=%b out_ready=%b want 1/1", stall, md_out_ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || md_in_valid !== 1'b0 || md_out_ready !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL rst_mid_wait hi=%h lo=%h in_valid=%b out_ready=%b stall=%b want 0",
                           hi, lo, md_in_valid, md_out_ready, stall);
    end
    $display("txn reset_mid_wait: hi=%h lo=%h stall=%b", hi, lo, stall);
    req_valid = 1'b0;
  endtask

`ifdef MADD_ACC_EN
  task automatic test_madd();
    tick();
    req_valid = 1'b1; req_op = REQ_MTHI; req_a = 32'd0;
    tick();
    req_op = REQ_MTLO; req_a = 32'd5;
    tick();
    req_op = REQ_MADD; req_a = 32'd3; req_b = 32'd4;
    md_in_ready = 1'b1; md_out_valid = 1'b0;
    tick();
    req_valid = 1'b0;
    #1;
    checks++;
    if (md_in_valid !== 1'b1 || md_op !== MD_MUL || md_sign !== 1'b1) begin
      failures++; $display("FAIL madd_issue valid=%b op=%b sign=%b want 1/01/1", md_in_valid, md_op, md_sign);
    end
    tick();
    md_out_valid = 1'b1; md_res0 = 32'd12; md_res1 = 32'd0;
    tick();
    md_out_valid = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd17) begin
      failures++; $display("FAIL madd_result hi=%h lo=%h want 0/11", hi, lo);
    end
    $display("txn madd: hi=%h lo=%h", hi, lo);
    req_valid = 1'b1; req_op = REQ_MTLO; req_a = 32'd0;
    tick();
    req_op = REQ_MSUB; req_a = 32'd1; req_b = 32'd1;
    tick();
    req_valid = 1'b0;
    tick();
    md_out_valid = 1'b1; md_res0 = 32'd1; md_res1 = 32'd0;
    tick();
    md_out_valid = 1'b0;
    #1;
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL msub_result hi=%h lo=%h want ffffffff/ffffffff", hi, lo);
    end
    $display("txn msub: hi=%h lo=%h", hi, lo);
  endtask
`else
  task automatic test_madd();
    tick();
    req_valid = 1'b1; req_op = REQ_MTHI; req_a = 32'hA;
    tick();
    req_op = REQ_MTLO; req_a = 32'hB;
    tick();
    req_op = REQ_MADD; req_a = 32'd3; req_b = 32'd4;
    md_in_ready = 1'b1; md_out_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL madd_off_stall stall=%b want 0", stall); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++;
    if (md_in_valid !== 1'b0 || hi !== 32'hA || lo !== 32'hB) begin
      failures++; $display("FAIL madd_off_nop in_valid=%b hi=%h lo=%h want 0/a/b", md_in_valid, hi, lo);
    end
    // While a MULT is outstanding, MADD still must not stall
    req_valid = 1'b1; req_op = REQ_MULT; req_a = 32'd2; req_b = 32'd3;
    tick();
    req_op = REQ_MSUBU;
    tick(); // WAIT
    #1;
    checks++;
    if (stall !== 1'b0 || md_out_ready !== 1'b1) begin
      failures++; $display("FAIL madd_off_busy stall=%b out_ready=%b want 0/1", stall, md_out_ready);
    end
    req_valid = 1'b0;
    md_out_valid = 1'b1; md_res0 = 32'd6; md_res1 = 32'd0;
    tick();
    md_out_valid = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin
      failures++; $display("FAIL madd_off_mult hi=%h lo=%h want 0/6", hi, lo);
    end
    $display("txn madd_disabled: hi=%h lo=%h", hi, lo);
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; req_valid = 1'b0; req_op = REQ_NOP; req_a = '0; req_b = '0;
    md_in_ready = 1'b0; md_out_valid = 1'b0; md_res0 = '0; md_res1 = '0;
    test_reset();
    test_mult(REQ_MULT,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    test_mult(REQ_MULTU, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    test_reset_mid_wait();
    test_div_slow();
    test_mt();
    test_back_to_back();
    test_madd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- Pipeline-side initiator for the multiply/divide unit's valid/ready request/response interface.
- Accepts mult/div/move requests from the execute stage and latches operands.
- Drives the unit's request channel and consumes its response channel.
- Owns the architectural HI/LO registers and raises a pipeline stall while a mult/div is outstanding.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  execute-stage request present
- req_op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU
- req_a  in  32  rs operand (dividend / multiplicand / MT data)
- req_b  in  32  rt operand (divisor / multiplier)
- stall  out  1  freeze execute and earlier stages; the request is not accepted this cycle
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- md_src0  out  32  latched req_a
- md_src1  out  32  latched req_b
- md_op  out  2  00 idle, 01 MUL, 10 DIV
- md_sign  out  1  signed operation
- md_in_valid  out  1  request-channel valid
- md_in_ready  in  1  request-channel ready
- md_out_valid  in  1  response-channel valid
- md_out_ready  out  1  response-channel ready
- md_res0  in  32  result low / quotient
- md_res1  in  32  result high / remainder

Behaviour:
- Reset values: hi=0, lo=0, md_src0=0, md_src1=0, md_op=0, md_sign=0, md_in_valid=0, md_out_ready=0; state IDLE.
- Reset wins over every other event, including mid-operation. The unit shares the same reset, so no drain is needed.
- FSM states:
  - IDLE: accept one request per cycle.
  - ISSUE: md_in_valid=1, md_op/md_sign/md_src* held from the latched copy.
  - WAIT: md_out_ready=1.
- Transitions:
  - IDLE -> ISSUE on an accepted MULT/MULTU/DIV/DIVU (and MADD* when enabled). Operands, op and sign are latched that edge.
  - ISSUE -> WAIT on md_in_valid & md_in_ready.
  - WAIT -> IDLE on md_out_valid & md_out_ready.
- Write-back on the response handshake:
  - MUL: {hi,lo} <= {md_res1, md_res0}.
  - DIV: lo <= md_res0 (quotient), hi <= md_res1 (remainder).
  - New values are visible the cycle after the handshake.
- Request channel: md_in_valid, once high, stays high with stable payload until accepted. md_op is 00 in all cycles outside ISSUE.
- Stall: stall = req_valid & (state != IDLE) & op in {1..12}. NOP never stalls. The pipeline holds the same request while stall=1.
- MTHI/MTLO in IDLE: write hi/lo at the edge, visible next cycle.
- MFHI/MFLO in IDLE: no action; the pipeline reads hi/lo combinationally.
- Divide by zero: HI/LO take whatever the unit returns; no trap.
- Minimum latency for MULT accepted at cycle 0:
  - Cycle 1: issue handshake.
  - Cycle 2: response (unit single-cycle), write-back.
  - Cycle 3: hi/lo valid; stall is low for dependent requests presented in cycle 3.
- Response arriving in the same cycle as a new request: the request still sees stall=1 (state is WAIT); it is accepted the next cycle.
- Unused req_op codes 13-15: treated as NOP.

Optional Feature:
- Macro MADD_ACC_EN.
- Defined: MADD/MADDU issue as MUL (signed for MADD/MSUB) and set an accumulate flag. On response, {hi,lo} <= {hi,lo} + {res1,res0} for MADD*, or {hi,lo} - {res1,res0} for MSUB*, as a 64-bit wrap-around sum.
- Not defined: codes 9-12 are treated as NOP (no stall, no state change).

Decomposition:
- Shared package holds:
  - req_op encodings (REQ_NOP..REQ_MSUBU).
  - md_op encodings MD_IDLE=2'b00, MD_MUL=2'b01, MD_DIV=2'b10, shared with the multiply/divide unit.
  - FSM state enum IDLE/ISSUE/WAIT.
- One natural sub-module: hilo_regfile. It holds HI/LO, the MT write port, the result write-back mux and the optional accumulate adder. The FSM stays in the top.

Test Plan:
- Reset mid-WAIT (DIV outstanding) -> next cycle hi=0, lo=0, md_in_valid=0, md_out_ready=0, stall=0.
- MULT a=0xFFFFFFFF, b=2, unit in_ready immediate, single-cycle response -> md_sign=1, md_op=01; hi=0xFFFFFFFF, lo=0xFFFFFFFE at cycle 3. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7, b=2, response delayed 20 cycles after in handshake -> stall=1 for a held MFLO throughout; afterwards lo=0xFFFFFFFD, hi=0xFFFFFFFF. md_src0/src1/op stable while md_in_ready held low 5 cycles.
- MTHI 0x1234 then MFHI back-to-back in IDLE -> no stall; hi=0x1234 on the cycle after MTHI.
- MULT issued while WAIT of a prior DIVU -> stall=1 until the DIVU response, MULT accepted the next cycle; final hi/lo reflect the MULT.
- MADD_ACC_EN defined: hi/lo=0/5, MADD a=3, b=4 -> lo=17, hi=0. MSUB with lo=0, hi=0, a=1, b=1 -> hi=lo=0xFFFFFFFF. Macro undefined: MADD produces no stall and no change.
